// File: rtl/font_loader.sv
// Font loader: parses framed glyph bitmaps from a byte stream and writes them into font RAM.
// Latency: a row byte accepted in cycle k is written in cycle k+1; done/err follow the checksum by one cycle.
// Backpressure: none; in_ready stays high from the first edge after reset, bytes are consumed as they arrive.
module font_loader #(
    parameter logic [7:0] START_BYTE = 8'hF0,
    parameter int         ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GLYPH = 3'd1,
        COUNT = 3'd2,
        DATA  = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic [11:0]       cnt_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        xor_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              done_q;
    logic              err_q;

    logic xfer;
    logic start_xfer, glyph_xfer, count_xfer, row_xfer, chk_xfer;

    assign xfer = in_valid & ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over a simultaneous transfer: no strobe fires, so the byte is dropped.
    always_comb begin
        state_d    = state_q;
        start_xfer = 1'b0;
        glyph_xfer = 1'b0;
        count_xfer = 1'b0;
        row_xfer   = 1'b0;
        chk_xfer   = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (in_data == START_BYTE) begin
                        state_d    = GLYPH;
                        start_xfer = 1'b1;
                    end
                end
                GLYPH: begin
                    state_d    = COUNT;
                    glyph_xfer = 1'b1;
                end
                COUNT: begin
                    state_d    = DATA;
                    count_xfer = 1'b1;
                end
                DATA: begin
                    row_xfer = 1'b1;
                    if (cnt_q == 12'd1) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    state_d  = IDLE;
                    chk_xfer = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A count of 0 loads 0 into the 12-bit counter, which then wraps through 4096 row bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            xor_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            wr_en_q <= row_xfer;
            done_q  <= chk_xfer;
            if (start_xfer) begin
                xor_q <= '0;
                err_q <= 1'b0;
            end
            if (glyph_xfer) begin
                ptr_q <= ADDR_W'({in_data, 4'b0000});
            end
            if (count_xfer) begin
                cnt_q <= {in_data, 4'b0000};
            end
            if (row_xfer) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= in_data;
                ptr_q     <= ptr_q + ADDR_W'(1);
                cnt_q     <= cnt_q - 12'd1;
                xor_q     <= xor_q ^ in_data;
            end
            if (chk_xfer && (in_data != xor_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign in_ready = ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_font_loader.sv
// Directed bench for font_loader: frames, wrap, checksum errors, noise/gaps, abort and reset mid-frame.
module tb_font_loader;

    localparam logic [7:0] START_BYTE = 8'hF0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        abort;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int          tests    = 0;
    int          fails    = 0;
    int          done_cnt = 0;
    bit          gaps     = 1'b0;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    logic [7:0]  rows[$];

    font_loader #(.START_BYTE(START_BYTE), .ADDR_W(12)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .abort    (abort),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_addr, wr_data});
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit ab);
        int n;
        n = 0;
        if (gaps) begin
            in_data  = 8'($urandom);
            in_valid = 1'b0;
            idle($urandom_range(0, 2));
        end
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) check("ready_timeout", in_ready, 1);
        in_data  = b;
        in_valid = 1'b1;
        abort    = ab;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    function automatic logic [7:0] row_xor();
        logic [7:0] x;
        x = 8'h00;
        foreach (rows[i]) x = x ^ rows[i];
        return x;
    endfunction

    task automatic send_frame(input logic [7:0] g, input logic [7:0] c, input logic [7:0] csum,
                              input bit lat);
        int nrows;
        nrows = (c == 8'd0) ? 4096 : int'(c) * 16;
        send(START_BYTE, 1'b0);
        check("busy_after_start", busy, 1);
        send(g, 1'b0);
        send(c, 1'b0);
        for (int i = 0; i < nrows; i++) begin
            send(rows[i], 1'b0);
            exp_q.push_back({12'(int'(g) * 16 + i), rows[i]});
            if (lat) begin
                check("wr_latency_en", wr_en, 1);
                check("wr_latency_dat", wr_data, rows[i]);
            end
        end
        send(csum, 1'b0);
        check("done_next_cycle", done, 1);
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic finish_frame(input string tag, input int exp_done, input logic exp_err);
        idle(3);
        check_writes(tag);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy"}, busy, 0);
        done_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        abort    = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", in_ready, 0);
        idle(1);
        check("ready_after_edge", in_ready, 1);

        // Basic frame: glyph 0x41, one glyph, rows 00..0F, checksum 00.
        rows.delete();
        for (int i = 0; i < 16; i++) rows.push_back(8'(i));
        send_frame(8'h41, 8'h01, 8'h00, 1'b1);
        finish_frame("basic", 1, 1'b0);

        // Address wrap: glyph 0xFF, two glyphs of AA.
        rows.delete();
        for (int i = 0; i < 32; i++) rows.push_back(8'hAA);
        send_frame(8'hFF, 8'h02, 8'h00, 1'b0);
        finish_frame("wrap", 1, 1'b0);

        // Bad checksum: writes still land, err sets.
        rows.delete();
        for (int i = 0; i < 16; i++) rows.push_back(8'(i));
        send_frame(8'h41, 8'h01, 8'h01, 1'b0);
        finish_frame("badsum", 1, 1'b1);

        // Noise bytes in IDLE, then a gapped frame; its start byte clears err.
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        check("noise_busy", busy, 0);
        check("noise_err_kept", err, 1);
        send(START_BYTE, 1'b0);
        check("start_clears_err", err, 0);
        gaps = 1'b1;
        rows.delete();
        for (int i = 0; i < 16; i++) rows.push_back(8'(i * 37 + 3));
        rows[5] = START_BYTE;
        send(8'h10, 1'b0);
        send(8'h01, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(rows[i], 1'b0);
            exp_q.push_back({12'h100 + 12'(i), rows[i]});
        end
        send(row_xor(), 1'b0);
        gaps = 1'b0;
        finish_frame("noise", 1, 1'b0);

        // Abort with the 5th row byte.
        rows.delete();
        for (int i = 0; i < 16; i++) rows.push_back(8'h80 + 8'(i));
        send(START_BYTE, 1'b0);
        send(8'h20, 1'b0);
        send(8'h01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(rows[i], 1'b0);
            exp_q.push_back({12'h200 + 12'(i), rows[i]});
        end
        send(rows[4], 1'b1);
        check("abort_busy", busy, 0);
        check("abort_no_write", wr_en, 0);
        finish_frame("abort", 0, 1'b0);

        // Reset after 3 row bytes, then a full-memory frame with count 0.
        send(START_BYTE, 1'b0);
        send(8'h30, 1'b0);
        send(8'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(8'h60 + 8'(i), 1'b0);
            exp_q.push_back({12'h300 + 12'(i), 8'h60 + 8'(i)});
        end
        idle(1);
        reset_n = 1'b0;
        idle(3);
        check_reset_outputs("midreset");
        check_writes("midreset");
        reset_n = 1'b1;
        #1;
        check("midreset_ready_before_edge", in_ready, 0);
        idle(1);
        check("midreset_ready_after_edge", in_ready, 1);
        done_cnt = 0;

        rows.delete();
        for (int i = 0; i < 4096; i++) rows.push_back(8'(i ^ (i >> 8)));
        send_frame(8'h00, 8'h00, row_xor(), 1'b0);
        finish_frame("count0", 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
